b11_feeder: RTL

Upstream stage for the b11 datapath: it buffers 6-bit sample words and drives b11's x_in/stbi pair.
- b11 stalls while stbi=1 and samples x_in on the cycle stbi=0.
- The feeder holds stbi high and presents each queued word with a one-cycle setup.
- It then pulses stbi low for exactly one cycle and enforces a configurable guard gap, so b11 can finish its arithmetic states before the next release.
- The write side is a simple push/full interface fed by the test source or a scan loader.

---
 rtl/b11_pkg.sv | 14 +
 rtl/b11_feeder_fifo.sv | 55 +++++
 rtl/b11_feeder.sv | 89 ++++++++
 3 files changed

// File: rtl/b11_pkg.sv
// Shared types and constants for the b11 datapath feeder.
package b11_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RELEASE,
        HOLD
    } feeder_state_t;

    localparam int   B11_WIDTH       = 6;
    localparam logic B11_STB_RELEASE = 1'b0;

endpackage

// File: rtl/b11_feeder_fifo.sv
// Synchronous FIFO buffering sample words for the b11 feeder.
module b11_feeder_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty gate the requests so the pointers can never cross.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/b11_feeder.sv
// Feeds queued words to b11 as a one-cycle stbi-low release
// followed by a guard gap.
module b11_feeder
    import b11_pkg::*;
#(
    parameter int WIDTH = B11_WIDTH,
    parameter int DEPTH = 4,
    parameter int GAP   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     push,
    input  logic                     pause,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [WIDTH-1:0]         x_feed,
    output logic                     stbi
);

    localparam int GW = $clog2(GAP) + 1;

    feeder_state_t    state;
    feeder_state_t    next_state;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] head;
    logic             pop;
    logic             stbi_d;

    b11_feeder_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .push     (push),
        .pop      (pop),
        .data_out (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!empty && !pause) next_state = SETUP;
            SETUP:   next_state = RELEASE;
            RELEASE: next_state = HOLD;
            HOLD:    if (gap_cnt == '0) next_state = IDLE;
        endcase
    end

    // stbi is registered from next_state so it tracks RELEASE exactly.
    always_comb begin
        pop    = (state == IDLE) && !empty && !pause;
        stbi_d = (next_state == RELEASE) ? B11_STB_RELEASE : ~B11_STB_RELEASE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            x_feed   <= '0;
            stbi     <= ~B11_STB_RELEASE;
            gap_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            stbi <= stbi_d;
            if (pop)
                x_feed <= head;
            if (state == RELEASE)
                gap_cnt <= GW'(GAP - 1);
            else if (state == HOLD && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (push && full)
                overflow <= 1'b1;
        end
    end

endmodule
